// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - LD_* encodings of the e_load_inst field
//   - lsu_state_t: FSM state encoding (IDLE / REQ / WAIT)
//   - acc_size(): access size in bytes of a load op / store mask
package lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;
  localparam logic [2:0] LD_WU   = 3'd6;
  localparam logic [2:0] LD_D    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // A non-zero store mask takes precedence over the load op, matching the
  // "store wins" rule. The mask is unshifted, so its highest set bit gives
  // the size directly.
  function automatic logic [3:0] acc_size(input logic [2:0] load_op,
                                          input logic [7:0] mask);
    logic [3:0] sz;
    sz = 4'd1;
    if (mask != 8'd0) begin
      if (mask[7])      sz = 4'd8;
      else if (mask[3]) sz = 4'd4;
      else if (mask[1]) sz = 4'd2;
      else              sz = 4'd1;
    end else begin
      case (load_op)
        LD_B, LD_BU: sz = 4'd1;
        LD_H, LD_HU: sz = 4'd2;
        LD_W, LD_WU: sz = 4'd4;
        LD_D:        sz = 4'd8;
        default:     sz = 4'd1;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   Store side (accept-time inputs):
//     st_off, st_load_op, st_mask, st_data -> st_wdata_lane, st_wmask_lane, misalign
//   Load side (response-time inputs, from latched op):
//     ld_off, ld_op, ld_rdata -> ld_result (lane-shifted, sign/zero-extended)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] st_off,
  input  logic [2:0]                      st_load_op,
  input  logic [DATA_WIDTH/8-1:0]         st_mask,
  input  logic [DATA_WIDTH-1:0]           st_data,
  output logic [DATA_WIDTH-1:0]           st_wdata_lane,
  output logic [DATA_WIDTH/8-1:0]         st_wmask_lane,
  output logic                            misalign,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] ld_off,
  input  logic [2:0]                      ld_op,
  input  logic [DATA_WIDTH-1:0]           ld_rdata,
  output logic [DATA_WIDTH-1:0]           ld_result
);

  logic [3:0]            sz;
  logic [DATA_WIDTH-1:0] sh;

  assign st_wdata_lane = st_data << {st_off, 3'b000};
  assign st_wmask_lane = st_mask << st_off;

  // Misaligned when any offset bit below the access size is set.
  always_comb begin
    sz       = acc_size(st_load_op, 8'(st_mask));
    misalign = |(4'(st_off) & (sz - 4'd1));
  end

  always_comb begin
    sh        = ld_rdata >> {ld_off, 3'b000};
    ld_result = sh;
    case (ld_op)
      LD_B:    ld_result = DATA_WIDTH'($signed(sh[7:0]));
      LD_H:    ld_result = DATA_WIDTH'($signed(sh[15:0]));
      LD_W:    ld_result = DATA_WIDTH'($signed(sh[31:0]));
      LD_BU:   ld_result = DATA_WIDTH'(sh[7:0]);
      LD_HU:   ld_result = DATA_WIDTH'(sh[15:0]);
      LD_WU:   ld_result = DATA_WIDTH'(sh[31:0]);
      default: ld_result = sh;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: MEM-stage load/store unit with one outstanding bus transaction.
//   EX side : e_valid/e_ready, e_regW, e_regAddr, e_regData (also the
//             effective address), e_load_inst, e_store_mask, e_store_data
//   Bus     : req_valid/req_ready, req_addr, req_wen, req_wdata, req_wmask,
//             rsp_valid, rsp_rdata
//   WB side : m_valid/m_ready, m_regW, m_regAddr, m_regData, m_misalign
//   Debug   : dbg_state (current FSM state)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; a producer holding valid keeps its payload stable until
// that edge, and ready may depend combinationally on the consumer's state.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    e_valid,
  output logic                    e_ready,
  input  logic                    e_regW,
  input  logic [ADDR_WIDTH-1:0]   e_regAddr,
  input  logic [DATA_WIDTH-1:0]   e_regData,
  input  logic [2:0]              e_load_inst,
  input  logic [DATA_WIDTH/8-1:0] e_store_mask,
  input  logic [DATA_WIDTH-1:0]   e_store_data,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [MEM_AW-1:0]       req_addr,
  output logic                    req_wen,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_regW,
  output logic [ADDR_WIDTH-1:0]   m_regAddr,
  output logic [DATA_WIDTH-1:0]   m_regData,
  output logic                    m_misalign,
  output lsu_state_t              dbg_state
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t state, state_n;

  // Op latched at accept, consumed when the response returns.
  logic [2:0]            op_load;
  logic                  op_store;
  logic                  op_regW;
  logic [ADDR_WIDTH-1:0] op_regAddr;
  logic [DATA_WIDTH-1:0] op_regData;
  logic [OFF_W-1:0]      op_off;

  logic                  slot_free, accept, is_store, is_mem, misalign_e;
  logic [OFF_W-1:0]      e_off;
  logic [MEM_AW-1:0]     e_addr;
  logic [DATA_WIDTH-1:0] wdata_lane, ld_result;
  logic [NB-1:0]         wmask_lane;

  // Slot-load controls from the FSM.
  logic                  go_req, slot_load, slot_misalign, slot_regW;
  logic [ADDR_WIDTH-1:0] slot_regAddr;
  logic [DATA_WIDTH-1:0] slot_regData;

  assign slot_free = !m_valid || m_ready;
  assign e_ready   = (state == IDLE) && slot_free;
  assign accept    = e_valid && e_ready;
  assign is_store  = |e_store_mask;
  assign is_mem    = is_store || (e_load_inst != LD_NONE);
  assign e_off     = e_regData[OFF_W-1:0];
  assign e_addr    = MEM_AW'(e_regData) & ~MEM_AW'(NB - 1);
  assign req_valid = (state == REQ);
  assign dbg_state = state;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_off        (e_off),
    .st_load_op    (e_load_inst),
    .st_mask       (e_store_mask),
    .st_data       (e_store_data),
    .st_wdata_lane (wdata_lane),
    .st_wmask_lane (wmask_lane),
    .misalign      (misalign_e),
    .ld_off        (op_off),
    .ld_op         (op_load),
    .ld_rdata      (rsp_rdata),
    .ld_result     (ld_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    go_req        = 1'b0;
    slot_load     = 1'b0;
    slot_misalign = 1'b0;
    slot_regW     = 1'b0;
    slot_regAddr  = e_regAddr;
    slot_regData  = e_regData;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem && misalign_e) begin
            slot_load     = 1'b1;
            slot_misalign = 1'b1;
          end else if (is_mem) begin
            go_req  = 1'b1;
            state_n = REQ;
          end else begin
            slot_load = 1'b1;
            slot_regW = e_regW;
          end
        end
      end
      REQ: begin
        if (req_ready) state_n = WAIT;
      end
      WAIT: begin
        // The slot is always empty here (accept needed a free slot and no
        // other source can fill it); the guard keeps the slot stable anyway.
        if (rsp_valid && slot_free) begin
          slot_load    = 1'b1;
          slot_regW    = op_regW && !op_store;
          slot_regAddr = op_regAddr;
          slot_regData = op_store ? op_regData : ld_result;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request fields and latched op: written only on the REQ transition, so
  // they stay stable for the whole REQ/WAIT period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr   <= '0;
      req_wen    <= 1'b0;
      req_wdata  <= '0;
      req_wmask  <= '0;
      op_load    <= LD_NONE;
      op_store   <= 1'b0;
      op_regW    <= 1'b0;
      op_regAddr <= '0;
      op_regData <= '0;
      op_off     <= '0;
    end else if (go_req) begin
      req_addr   <= e_addr;
      req_wen    <= is_store;
      req_wdata  <= wdata_lane;
      req_wmask  <= wmask_lane;
      op_load    <= e_load_inst;
      op_store   <= is_store;
      op_regW    <= e_regW;
      op_regAddr <= e_regAddr;
      op_regData <= e_regData;
      op_off     <= e_off;
    end
  end

  // Output slot: a load in the same cycle as m_ready replaces the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_regW     <= 1'b0;
      m_regAddr  <= '0;
      m_regData  <= '0;
      m_misalign <= 1'b0;
    end else if (slot_load) begin
      m_valid    <= 1'b1;
      m_regW     <= slot_regW;
      m_regAddr  <= slot_regAddr;
      m_regData  <= slot_regData;
      m_misalign <= slot_misalign;
    end else if (m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule
